dmem_resume_ctrl: RTL and testbench

//   Responder for the dmem_stall/dmem_resume handshake raised by the Decode stage on LW/SW.

---
 rtl/dmem_resume_ctrl.sv | 99 +++++++++
 tb/tb_dmem_resume_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resume_ctrl.sv
// rtl/dmem_resume_ctrl.sv - Memory-stage load/store responder for the Decode stall/resume handshake.
module dmem_resume_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_stall,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic        dmem_resume,
  output logic [31:0] rdata_m,
  output logic        access_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            holdoff;
  logic            we_q;
  logic            err_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            capture;
  logic            misalign;
  logic            complete;
  logic            timeout;

  always_comb begin
    capture   = (state == IDLE) && dmem_stall && (mem_read_m || mem_write_m) && !holdoff;
    misalign  = (addr_m[1:0] != 2'b00);
    complete  = ((state == ISSUE) && bus_gnt && bus_rvalid) || ((state == WAIT) && bus_rvalid);
    // Completion in the final budget cycle beats the timeout.
    timeout   = ((state == ISSUE) || (state == WAIT)) && !complete &&
                (cnt == CW'(TIMEOUT_CYCLES - 1));
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = misalign ? DONE : ISSUE;
      ISSUE:   if (complete || timeout) state_nxt = DONE;
               else if (bus_gnt) state_nxt = WAIT;
      WAIT:    if (complete || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      holdoff <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_m <= '0;
    end else begin
      // Decode's stall is still high in the cycle after DONE; don't re-capture it.
      holdoff <= (state == DONE);
      if (capture) begin
        we_q    <= mem_write_m;
        addr_q  <= {addr_m[31:2], 2'b00};
        wdata_q <= wdata_m;
        err_q   <= misalign;
        cnt     <= '0;
        if (misalign && !mem_write_m) rdata_m <= '0;
      end
      if ((state == ISSUE) || (state == WAIT)) cnt <= cnt + CW'(1);
      if (timeout) begin
        err_q <= 1'b1;
        if (!we_q) rdata_m <= '0;
      end
      if (complete && !we_q) rdata_m <= bus_rdata;
    end
  end

  assign dmem_resume = (state == DONE);
  assign access_err  = (state == DONE) && err_q;
  assign bus_req     = (state == ISSUE);
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;

endmodule

// File: tb/tb_dmem_resume_ctrl.sv
// tb/tb_dmem_resume_ctrl.sv - Scoreboard bench for dmem_resume_ctrl with randomized memory timing.
module tb_dmem_resume_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmem_stall = 1'b0;
  logic        mem_read_m = 1'b0;
  logic        mem_write_m = 1'b0;
  logic [31:0] addr_m = '0;
  logic [31:0] wdata_m = '0;
  logic        dmem_resume;
  logic [31:0] rdata_m;
  logic        access_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  dmem_resume_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .dmem_stall(dmem_stall), .mem_read_m(mem_read_m),
    .mem_write_m(mem_write_m), .addr_m(addr_m), .wdata_m(wdata_m),
    .dmem_resume(dmem_resume), .rdata_m(rdata_m), .access_err(access_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          nreq;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_rdata = '0;
  int          req_cnt = 0;

  // Monitor: bus fields every request cycle, result on every resume pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      req_cnt = 0;
    end else if (sb.size() == 0) begin
      n_cmp++;
      if (bus_req || dmem_resume) begin
        n_bad++;
        $display("FAIL idle_quiet: bus_req=%0b dmem_resume=%0b, required 0/0", bus_req, dmem_resume);
      end
    end else begin
      e = sb[0];
      if (bus_req) begin
        req_cnt++;
        n_cmp++;
        if (bus_we !== e.we || bus_addr !== e.addr || bus_wdata !== e.wdata) begin
          n_bad++;
          $display("FAIL bus_fields: we=%0b addr=%h wdata=%h, required %0b %h %h",
                   bus_we, bus_addr, bus_wdata, e.we, e.addr, e.wdata);
        end
      end
      if (dmem_resume) begin
        n_cmp++;
        if (access_err !== e.err || rdata_m !== e.rdata || req_cnt != e.nreq) begin
          n_bad++;
          $display("FAIL resume: err=%0b rdata=%h nreq=%0d, required %0b %h %0d",
                   access_err, rdata_m, req_cnt, e.err, e.rdata, e.nreq);
        end
        void'(sb.pop_front());
        req_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // g: ISSUE cycle index carrying gnt; r: cycles from gnt to rvalid (0 = same cycle).
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input int g, input int r, input logic [31:0] rdv, input bit stray);
    exp_t e;
    bit   mis, to;
    int   c, lat, k;
    mis = (a[1:0] != 2'b00);
    c   = g + r;
    to  = !mis && (c > T - 1);
    e.we    = wr;
    e.addr  = {a[31:2], 2'b00};
    e.wdata = wd;
    e.err   = mis || to;
    e.nreq  = mis ? 0 : ((g + 1 < T) ? g + 1 : T);
    lat     = mis ? 0 : (to ? T : c + 1);
    if (!wr) model_rdata = e.err ? 32'h0 : rdv;
    e.rdata = model_rdata;
    sb.push_back(e);

    dmem_stall = 1'b1; mem_read_m = rd; mem_write_m = wr; addr_m = a; wdata_m = wd;
    tick();
    k = 0;
    while (!dmem_resume && k < 40) begin
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (bus_req && k == g) begin
        bus_gnt = 1'b1;
        if (r == 0) begin bus_rvalid = 1'b1; bus_rdata = rdv; end
      end else if (!bus_req && r != 0 && k == c) begin
        bus_rvalid = 1'b1; bus_rdata = rdv;
      end
      tick();
      k++;
    end
    n_cmp++;
    if (k != lat) begin
      n_bad++;
      $display("FAIL latency: resume after %0d cycles, required %0d (addr %h)", k, lat, a);
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    tick();
    // Holdoff cycle: stall and op still present; optional stray response.
    if (stray) begin bus_rvalid = 1'b1; bus_rdata = $urandom; end
    tick();
    bus_rvalid = 1'b0; dmem_stall = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({dmem_resume, access_err, bus_req, bus_we} !== 4'b0 || rdata_m !== 32'h0 ||
        bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL %s: resume=%0b err=%0b req=%0b we=%0b rdata=%h addr=%h wdata=%h, required all 0",
               name, dmem_resume, access_err, bus_req, bus_we, rdata_m, bus_addr, bus_wdata);
    end
  endtask

  initial begin
    bit          rd, wr;
    logic [31:0] a;
    int          op;

    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    check_zero("reset_state");
    bus_rvalid = 1'b0;
    rst = 1'b0;
    tick();

    // Stall with no op, and op with no stall: both ignored.
    dmem_stall = 1'b1;
    repeat (3) tick();
    dmem_stall = 1'b0; mem_read_m = 1'b1; addr_m = 32'h40;
    repeat (3) tick();
    mem_read_m = 1'b0;

    do_op(1, 0, 32'h100, 32'h0, 0, 2, 32'hDEADBEEF, 0);
    do_op(0, 1, 32'h204, 32'h12345678, 2, 1, 32'h0BAD_0BAD, 0);
    do_op(1, 0, 32'h102, 32'h0, 0, 1, 32'h1111_1111, 0);
    do_op(1, 0, 32'h100, 32'h0, 0, 1, 32'h2222_2222, 0);
    do_op(1, 0, 32'h108, 32'h0, 9, 1, 32'h3333_3333, 1);
    do_op(1, 0, 32'h10C, 32'h0, 0, 0, 32'hA5A5A5A5, 0);
    do_op(1, 1, 32'h110, 32'hCAFE_F00D, 1, 1, 32'h4444_4444, 0);
    do_op(0, 1, 32'h113, 32'h5555_5555, 0, 1, 32'h6666_6666, 0);
    do_op(1, 0, 32'h114, 32'h0, 3, 0, 32'h7777_7777, 0);

    // Reset while waiting for the read response.
    begin
      exp_t e;
      e.we = 1'b0; e.addr = 32'h300; e.wdata = 32'h0; e.rdata = 32'h0; e.err = 1'b0; e.nreq = 1;
      sb.push_back(e);
    end
    dmem_stall = 1'b1; mem_read_m = 1'b1; addr_m = 32'h300; wdata_m = 32'h0;
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_zero("reset_mid_wait");
    rst = 1'b0; dmem_stall = 1'b0; mem_read_m = 1'b0;
    sb.delete();
    model_rdata = 32'h0;
    bus_rvalid = 1'b1; bus_rdata = 32'h9999_9999;
    tick();
    bus_rvalid = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      a  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_op(rd, wr, a, $urandom, $urandom_range(0, 4), $urandom_range(0, 3), $urandom,
            1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
